// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : shared state encoding and sizing helper for debounce_filter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_t;

    // Bits needed to hold values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
// ============================================================================
// sync_chain : plain flop shift chain bringing an asynchronous bit into clk
// Revision   : 1.0
// ============================================================================
`default_nettype none

module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_LEVEL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/debounce_filter.sv
// ============================================================================
// debounce_filter : synchronise, debounce and strobe a raw 1-bit input;
//                   aborted level changes are flagged and counted.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module debounce_filter
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter int   GLITCH_W      = 8,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_raw,
    input  logic                glitch_clr,
    output logic                a_clean,
    output logic                rise,
    output logic                fall,
    output logic                glitch,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic                busy
);

    localparam int                  CNT_W         = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]    C_CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    C_CNT_ONE     = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] C_GCNT_MAX    = '1;
    localparam deb_state_t          C_RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic                w_s;
    deb_state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_clean, w_clean_nxt;
    logic                r_rise, w_rise_nxt;
    logic                r_fall, w_fall_nxt;
    logic                r_glitch, w_glitch_nxt;
    logic [GLITCH_W-1:0] r_gcnt;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (a_raw),
        .q   (w_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= C_RESET_STATE;
            r_cnt    <= '0;
            r_clean  <= RESET_LEVEL;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clean  <= w_clean_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_clean_nxt  = r_clean;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_glitch_nxt = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_s) begin
                    // A one-cycle qualification window commits immediately
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = STABLE_HI;
                        w_clean_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = PEND_HI;
                        w_cnt_nxt   = C_CNT_ONE;
                    end
                end
            end
            STABLE_HI: begin
                if (!w_s) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = STABLE_LO;
                        w_clean_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = PEND_LO;
                        w_cnt_nxt   = C_CNT_ONE;
                    end
                end
            end
            PEND_HI: begin
                if (w_s) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = STABLE_HI;
                        w_clean_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end else begin
                    w_state_nxt  = STABLE_LO;
                    w_glitch_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end
            end
            PEND_LO: begin
                if (!w_s) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = STABLE_LO;
                        w_clean_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end else begin
                    w_state_nxt  = STABLE_HI;
                    w_glitch_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = C_RESET_STATE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Counter steps on the same edge the glitch strobe is raised; clear wins
    always_ff @(posedge clk) begin
        if (rst || glitch_clr) begin
            r_gcnt <= '0;
        end else if (w_glitch_nxt && (r_gcnt != C_GCNT_MAX)) begin
            r_gcnt <= r_gcnt + 1'b1;
        end
    end

    assign a_clean    = r_clean;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch     = r_glitch;
    assign glitch_cnt = r_gcnt;
    assign busy       = (r_state == PEND_HI) || (r_state == PEND_LO);

endmodule

`default_nettype wire
